// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Lets the instruction cache (port 0) and the data cache (port 1) share one
// backing block memory. One whole-block access runs at a time: a read or a
// write-back goes to the memory. When it completes, the read data and a
// one-cycle done pulse go back to the cache that owns the access. The other
// cache is held in busywait until it gets a grant.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  defined   -> port 1 always wins a simultaneous
//                                       request, so port 0 can starve.
//                          undefined -> round robin between the two ports.
//
// Ports:
//   clk_i, reset_i          clock and asynchronous active-low reset
//   p_read_i / p_wr_i       per-port block read / write-back requests ([k] = port k)
//   p0_addr_i, p1_addr_i    per-port block addresses
//   p0_wr_data_i,
//   p1_wr_data_i            per-port write-back data
//   p_busywait_o            per-port stall (combinational)
//   p_read_data_o           last block read, valid with p_read_done_o
//   p_read_done_o           one-cycle read-complete pulse to the owner
//   p_write_done_o          one-cycle write-complete pulse to the owner
//   m_read_o / m_wr_o       memory read / write command
//   m_addr_o, m_wr_data_o   memory address and write data, held for the access
//   m_busywait_i            memory busy (informational, not used)
//   m_read_data_i           memory read data, valid with m_read_done_i
//   m_read_done_i           memory read-complete pulse
//   m_write_done_i          memory write-complete pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         p_read_i,
  input  logic [1:0]         p_wr_i,
  input  logic [ADDR_W-1:0]  p0_addr_i,
  input  logic [ADDR_W-1:0]  p1_addr_i,
  input  logic [BLOCK_W-1:0] p0_wr_data_i,
  input  logic [BLOCK_W-1:0] p1_wr_data_i,
  output logic [1:0]         p_busywait_o,
  output logic [BLOCK_W-1:0] p_read_data_o,
  output logic [1:0]         p_read_done_o,
  output logic [1:0]         p_write_done_o,
  output logic               m_read_o,
  output logic               m_wr_o,
  output logic [ADDR_W-1:0]  m_addr_o,
  output logic [BLOCK_W-1:0] m_wr_data_o,
  input  logic               m_busywait_i,
  input  logic [BLOCK_W-1:0] m_read_data_i,
  input  logic               m_read_done_i,
  input  logic               m_write_done_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic               owner_reg, owner_next;
  logic               op_wr_reg, op_wr_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [BLOCK_W-1:0] wr_data_reg, wr_data_next;
  logic [BLOCK_W-1:0] read_data_reg, read_data_next;
  logic [1:0]         read_done_reg, read_done_next;
  logic [1:0]         write_done_reg, write_done_next;

  logic [1:0]         req;
  logic               grant;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic               last_grant_reg;
`endif

  // The memory's busy flag is not used to sequence accesses. The done
  // pulses are enough.
  logic               unused_m_busywait;
  assign unused_m_busywait = m_busywait_i;

  assign req = p_read_i | p_wr_i;

  // Winner selection. It is only used while IDLE.
  always_comb begin : winner_sel
    grant = 1'b0;
    case (req)
      2'b01: grant = 1'b0;
      2'b10: grant = 1'b1;
      2'b11: begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        grant = 1'b1;
`else
        grant = ~last_grant_reg;
`endif
      end
      default: grant = 1'b0;
    endcase
  end

  // Next-state logic and the done and data registers.
  always_comb begin : next_state
    state_next      = state_reg;
    owner_next      = owner_reg;
    op_wr_next      = op_wr_reg;
    addr_next       = addr_reg;
    wr_data_next    = wr_data_reg;
    read_data_next  = read_data_reg;
    read_done_next  = 2'b00;
    write_done_next = 2'b00;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          owner_next   = grant;
          // If a port requests both a write-back and a read, the write-back
          // goes first. The still-pending read is served by a later grant.
          op_wr_next   = p_wr_i[grant];
          addr_next    = grant ? p1_addr_i : p0_addr_i;
          wr_data_next = grant ? p1_wr_data_i : p0_wr_data_i;
          state_next   = ACCESS;
        end
      end
      ACCESS: begin
        // A done pulse of the wrong type is ignored.
        if (op_wr_reg) begin
          if (m_write_done_i) begin
            write_done_next[owner_reg] = 1'b1;
            state_next                 = RELEASE;
          end
        end else if (m_read_done_i) begin
          read_done_next[owner_reg] = 1'b1;
          read_data_next            = m_read_data_i;
          state_next                = RELEASE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin : state_regs
    if (!reset_i) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      op_wr_reg      <= 1'b0;
      addr_reg       <= '0;
      wr_data_reg    <= '0;
      read_data_reg  <= '0;
      read_done_reg  <= 2'b00;
      write_done_reg <= 2'b00;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      op_wr_reg      <= op_wr_next;
      addr_reg       <= addr_next;
      wr_data_reg    <= wr_data_next;
      read_data_reg  <= read_data_next;
      read_done_reg  <= read_done_next;
      write_done_reg <= write_done_next;
`ifndef MEM_ARB_FIXED_PRIO_EN
      if (state_reg == IDLE && |req) begin
        last_grant_reg <= grant;
      end
`endif
    end
  end

  // The commands are decoded from registered state. An asynchronous reset
  // therefore drops them immediately.
  assign m_read_o       = (state_reg == ACCESS) & ~op_wr_reg;
  assign m_wr_o         = (state_reg == ACCESS) &  op_wr_reg;
  assign m_addr_o       = addr_reg;
  assign m_wr_data_o    = wr_data_reg;
  assign p_read_data_o  = read_data_reg;
  assign p_read_done_o  = read_done_reg;
  assign p_write_done_o = write_done_reg;

  // A port stalls while it is requesting. The stall is released in the
  // cycle that carries its done pulse.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_busywait
      assign p_busywait_o[gi] = req[gi] & ~(read_done_reg[gi] | write_done_reg[gi]);
    end
  endgenerate

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int ADDR_W  = 28;
  localparam int BLOCK_W = 128;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic [1:0]         p_read_i, p_wr_i;
  logic [ADDR_W-1:0]  p0_addr_i, p1_addr_i;
  logic [BLOCK_W-1:0] p0_wr_data_i, p1_wr_data_i;
  logic [1:0]         p_busywait_o, p_read_done_o, p_write_done_o;
  logic [BLOCK_W-1:0] p_read_data_o, m_wr_data_o, m_read_data_i;
  logic               m_read_o, m_wr_o, m_busywait_i, m_read_done_i, m_write_done_i;
  logic [ADDR_W-1:0]  m_addr_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .p_read_i(p_read_i), .p_wr_i(p_wr_i),
    .p0_addr_i(p0_addr_i), .p1_addr_i(p1_addr_i),
    .p0_wr_data_i(p0_wr_data_i), .p1_wr_data_i(p1_wr_data_i),
    .p_busywait_o(p_busywait_o), .p_read_data_o(p_read_data_o),
    .p_read_done_o(p_read_done_o), .p_write_done_o(p_write_done_o),
    .m_read_o(m_read_o), .m_wr_o(m_wr_o), .m_addr_o(m_addr_o),
    .m_wr_data_o(m_wr_data_o), .m_busywait_i(m_busywait_i),
    .m_read_data_i(m_read_data_i), .m_read_done_i(m_read_done_i),
    .m_write_done_i(m_write_done_i)
  );

  // ---------------- memory model: 5-cycle latency, 1-cycle done ----------------
  logic [BLOCK_W-1:0] mem [0:15];
  logic [2:0]         lat_cnt;
  logic               mdone;
  logic               model_init;
  logic               inj_wdone;

  always @(posedge clk_i) begin
    if (model_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 128'hC0DE_0000 + 128'(i);
      lat_cnt <= 3'd0;
      mdone   <= 1'b0;
    end else if (!(m_read_o | m_wr_o)) begin
      lat_cnt <= 3'd0;
      mdone   <= 1'b0;
    end else if (mdone) begin
      mdone   <= 1'b0;
      lat_cnt <= 3'd0;
      if (m_wr_o) mem[m_addr_o[3:0]] <= m_wr_data_o;
    end else if (lat_cnt == 3'd3) begin
      mdone <= 1'b1;
    end else begin
      lat_cnt <= lat_cnt + 3'd1;
    end
  end

  assign m_read_data_i  = mdone ? mem[m_addr_o[3:0]] : '0;
  assign m_read_done_i  = mdone & m_read_o;
  assign m_write_done_i = (mdone & m_wr_o) | inj_wdone;
  assign m_busywait_i   = m_read_o | m_wr_o;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One cache transaction. The request is raised now and dropped in the
  // done cycle. exp_lat is the number of edges from the request to the
  // memory command.
  task automatic do_txn(input bit port, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [BLOCK_W-1:0] wdata, input logic [BLOCK_W-1:0] exp_rdata,
                        input int exp_lat, input string tag);
    int grant_cyc;
    int done_cyc;
    logic [ADDR_W-1:0]  seen_addr;
    logic [BLOCK_W-1:0] seen_wdata;
    bit bw_ok;
    bit other_done;
    grant_cyc = -1; done_cyc = -1; bw_ok = 1'b1; other_done = 1'b0;
    seen_addr = '0; seen_wdata = '0;
    if (port) begin p1_addr_i = addr; p1_wr_data_i = wdata; end
    else      begin p0_addr_i = addr; p0_wr_data_i = wdata; end
    if (wr) p_wr_i[port] = 1'b1; else p_read_i[port] = 1'b1;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(posedge clk_i); #1;
      if (grant_cyc < 0 && (wr ? m_wr_o : m_read_o)) begin
        grant_cyc = c; seen_addr = m_addr_o; seen_wdata = m_wr_data_o;
      end
      if (p_read_done_o[~port] | p_write_done_o[~port]) other_done = 1'b1;
      if (wr ? p_write_done_o[port] : p_read_done_o[port]) done_cyc = c;
      else if (!p_busywait_o[port]) bw_ok = 1'b0;
    end
    chk({tag, " done_seen"}, 128'(done_cyc > 0), 128'd1);
    chk({tag, " grant_lat"}, 128'(grant_cyc), 128'(exp_lat));
    chk({tag, " done_lat"}, 128'(done_cyc), 128'(exp_lat + 5));
    chk({tag, " m_addr"}, 128'(seen_addr), 128'(addr));
    if (wr) chk({tag, " m_wr_data"}, seen_wdata, wdata);
    else    chk({tag, " rdata"}, p_read_data_o, exp_rdata);
    chk({tag, " busywait_before_done"}, 128'(bw_ok), 128'd1);
    chk({tag, " busywait_in_done"}, 128'(p_busywait_o[port]), 128'd0);
    chk({tag, " cmd_low_in_release"}, 128'({m_read_o, m_wr_o}), 128'd0);
    chk({tag, " other_port_done"}, 128'(other_done), 128'd0);
    $display("txn %s port=%0d op=%s addr=%0h rdata=%0h grant_lat=%0d done_lat=%0d",
             tag, port, wr ? "wr" : "rd", addr, p_read_data_o, grant_cyc, done_cyc);
    if (wr) p_wr_i[port] = 1'b0; else p_read_i[port] = 1'b0;
  endtask

  task automatic apply_reset();
    reset_i = 1'b0; p_read_i = 2'b00; p_wr_i = 2'b00;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  typedef struct {
    bit                 port;
    bit                 wr;
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] wdata;
    logic [BLOCK_W-1:0] exp_rdata;
    string              name;
  } vec_t;

  vec_t               vecs[7];
  bit                 order[2];
  logic [BLOCK_W-1:0] rdat[2];
  bit                 grants[4];
  int                 n;
  bit                 bw1_ok, both;
  int                 dcyc;
  logic [BLOCK_W-1:0] bigdata;

  initial begin
    bigdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    vecs[0] = '{1'b0, 1'b0, 28'h3, '0,          128'hC0DE_0003, "v0 p0 rd 3"};
    vecs[1] = '{1'b1, 1'b1, 28'h5, 128'h3,      '0,             "v1 p1 wr 5"};
    vecs[2] = '{1'b1, 1'b0, 28'h5, '0,          128'h3,         "v2 p1 rd 5"};
    vecs[3] = '{1'b0, 1'b1, 28'h9, bigdata,     '0,             "v3 p0 wr 9"};
    vecs[4] = '{1'b1, 1'b0, 28'h9, '0,          bigdata,        "v4 p1 rd 9"};
    vecs[5] = '{1'b0, 1'b0, 28'h0, '0,          128'hC0DE_0000, "v5 p0 rd 0"};
    vecs[6] = '{1'b1, 1'b0, 28'hF, '0,          128'hC0DE_000F, "v6 p1 rd F"};

    p_read_i = 2'b00; p_wr_i = 2'b00; inj_wdone = 1'b0;
    p0_addr_i = '0; p1_addr_i = '0; p0_wr_data_i = '0; p1_wr_data_i = '0;
    model_init = 1'b1; reset_i = 1'b0;
    repeat (3) @(posedge clk_i); #1;
    model_init = 1'b0;

    // Reset state.
    chk("rst m_cmd", 128'({m_read_o, m_wr_o}), 128'd0);
    chk("rst dones", 128'({p_read_done_o, p_write_done_o}), 128'd0);
    chk("rst rdata", p_read_data_o, 128'd0);
    chk("rst m_addr", 128'(m_addr_o), 128'd0);
    chk("rst busywait_idle", 128'(p_busywait_o), 128'd0);
    p_read_i = 2'b01; #1;
    chk("rst busywait_req", 128'(p_busywait_o), 128'd1);
    p_read_i = 2'b00;
    @(posedge clk_i); #1 reset_i = 1'b1;
    @(posedge clk_i); #1;

    // Table-driven single-port transactions, each starting from IDLE.
    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1, vecs[i].name);
      repeat (2) @(posedge clk_i); #1;
    end

    // Write-back followed immediately by a fill. Between them come one
    // RELEASE cycle and one IDLE cycle.
    do_txn(1'b1, 1'b1, 28'h5, 128'h3, '0, 1, "t3 wb 5");
    do_txn(1'b1, 1'b0, 28'h7, '0, 128'hC0DE_0007, 2, "t3 fill 7");
    chk("t3 mem5", mem[5], 128'h3);
    repeat (2) @(posedge clk_i); #1;

    // Simultaneous reads after reset: port 0 is served first.
    apply_reset();
    p0_addr_i = 28'h3; p1_addr_i = 28'h5; p_read_i = 2'b11;
    n = 0; bw1_ok = 1'b1; both = 1'b0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(posedge clk_i); #1;
      if (p_read_done_o == 2'b11) both = 1'b1;
      if (p_read_i[1] && !p_read_done_o[1] && !p_busywait_o[1]) bw1_ok = 1'b0;
      if (p_read_done_o[0]) begin
        order[n] = 1'b0; rdat[n] = p_read_data_o; n++; p_read_i[0] = 1'b0;
      end else if (p_read_done_o[1]) begin
        order[n] = 1'b1; rdat[n] = p_read_data_o; n++; p_read_i[1] = 1'b0;
      end
    end
    p_read_i = 2'b00;
    chk("t2 count", 128'(n), 128'd2);
    chk("t2 first_port", 128'(order[0]), 128'd0);
    chk("t2 second_port", 128'(order[1]), 128'd1);
    chk("t2 rdata0", rdat[0], 128'hC0DE_0003);
    chk("t2 rdata1", rdat[1], 128'h3);
    chk("t2 busywait1", 128'(bw1_ok), 128'd1);
    chk("t2 both_done", 128'(both), 128'd0);
    $display("txn t2 dual read order=%0d,%0d", order[0], order[1]);
    repeat (2) @(posedge clk_i); #1;

    // Continuous requests from both ports for 4 accesses.
    apply_reset();
    p0_addr_i = 28'h1; p1_addr_i = 28'h2; p_read_i = 2'b11;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(posedge clk_i); #1;
      if (p_read_done_o[0]) begin grants[n] = 1'b0; n++; end
      else if (p_read_done_o[1]) begin grants[n] = 1'b1; n++; end
    end
    p_read_i = 2'b00;
    chk("t4 count", 128'(n), 128'd4);
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk($sformatf("t4 grant%0d", k), 128'(grants[k]), 128'd1);
`else
      chk($sformatf("t4 grant%0d", k), 128'(grants[k]), 128'(k % 2));
`endif
    end
    $display("txn t4 grants=%0d%0d%0d%0d", grants[0], grants[1], grants[2], grants[3]);
    repeat (2) @(posedge clk_i); #1;

    // Request dropped in the second ACCESS cycle.
    p0_addr_i = 28'h4; p_read_i[0] = 1'b1;
    @(posedge clk_i); #1;
    chk("t5 grant", 128'(m_read_o), 128'd1);
    @(posedge clk_i); #1;
    p_read_i[0] = 1'b0;
    dcyc = -1;
    for (int c = 1; c <= 20 && dcyc < 0; c++) begin
      @(posedge clk_i); #1;
      if (p_read_done_o[0]) dcyc = c;
    end
    chk("t5 done_after_drop", 128'(dcyc), 128'd4);
    chk("t5 rdata", p_read_data_o, 128'hC0DE_0004);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("t5 idle_no_cmd", 128'({m_read_o, m_wr_o}), 128'd0);
    $display("txn t5 dropped read done_cyc=%0d", dcyc);

    // A done pulse of the wrong type during a read is ignored.
    p0_addr_i = 28'h6; p_read_i[0] = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    inj_wdone = 1'b1;
    @(posedge clk_i); #1;
    inj_wdone = 1'b0;
    chk("t7 still_reading", 128'(m_read_o), 128'd1);
    chk("t7 no_done", 128'({p_read_done_o, p_write_done_o}), 128'd0);
    dcyc = -1;
    for (int c = 1; c <= 20 && dcyc < 0; c++) begin
      @(posedge clk_i); #1;
      if (p_read_done_o[0]) dcyc = c;
      if (p_write_done_o != 2'b00) dcyc = 99;
    end
    p_read_i[0] = 1'b0;
    chk("t7 read_done", 128'(dcyc), 128'd3);
    chk("t7 rdata", p_read_data_o, 128'hC0DE_0006);
    $display("txn t7 wrong-type done ignored");
    repeat (2) @(posedge clk_i); #1;

    // Reset during ACCESS drops the command at once and issues no done pulse.
    p1_addr_i = 28'h8; p1_wr_data_i = 128'h55; p_wr_i[1] = 1'b1;
    @(posedge clk_i); #1;
    chk("t6 wr_granted", 128'(m_wr_o), 128'd1);
    @(posedge clk_i); #3;
    reset_i = 1'b0;
    #1;
    chk("t6 cmd_dropped", 128'({m_read_o, m_wr_o}), 128'd0);
    chk("t6 no_done", 128'({p_read_done_o, p_write_done_o}), 128'd0);
    p_wr_i = 2'b00;
    @(posedge clk_i); #1 reset_i = 1'b1;
    @(posedge clk_i); #1;
    do_txn(1'b0, 1'b0, 28'h7, '0, 128'hC0DE_0007, 1, "t6 after reset");
    chk("t6 mem8_untouched", mem[8], 128'hC0DE_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
